wb_stage: RTL and testbench

Writeback stage of the five-stage RV32I pipeline, directly downstream of the MEM stage. It holds the MEM/WB pipeline register and extracts and sign/zero-extends load data from the raw memory word. It selects the writeback source and drives the register-file write port and the WB-to-EXE forwarding path. It also keeps a retired-instruction counter.

---
 rtl/wb_stage.sv | 150 +++++++++++++++
 tb/tb_wb_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RV32I writeback stage: MEM/WB register, load extraction, writeback mux, retire counter.
module wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_stall,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [4:0]       in_rd,
  input  logic             in_regwrite,
  input  logic [1:0]       in_wb_sel,
  input  logic [2:0]       in_funct3,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_alu_out,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_mem_rdata,
  output logic             rf_we,
  output logic [4:0]       rf_rd,
  output logic [31:0]      rf_wdata,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [31:0]      fwd_data,
  output logic             commit_valid,
  output logic [31:0]      commit_pc,
  output logic             load_misaligned,
  output logic [CNT_W-1:0] retired_count
);

  logic             valid_q, valid_d;
  logic [31:0]      pc_q, pc_d;
  logic [4:0]       rd_q, rd_d;
  logic             regwrite_q, regwrite_d;
  logic [1:0]       wb_sel_q, wb_sel_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       off_q, off_d;
  logic [31:0]      alu_q, alu_d;
  logic [31:0]      imm_q, imm_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Only the byte offset of the data address matters in writeback.
  logic unused_addr;
  assign unused_addr = ^in_addr[31:2];

  // A stalled MEM instruction becomes a bubble; payload fields simply hold.
  always_comb begin
    valid_d    = 1'b0;
    pc_d       = pc_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    wb_sel_d   = wb_sel_q;
    funct3_d   = funct3_q;
    off_d      = off_q;
    alu_d      = alu_q;
    imm_d      = imm_q;
    rdata_d    = rdata_q;
    if (!mem_stall) begin
      valid_d    = in_valid;
      pc_d       = in_pc;
      rd_d       = in_rd;
      regwrite_d = in_regwrite;
      wb_sel_d   = in_wb_sel;
      funct3_d   = in_funct3;
      off_d      = in_addr[1:0];
      alu_d      = in_alu_out;
      imm_d      = in_imm;
      rdata_d    = in_mem_rdata;
    end
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, valid_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      wb_sel_q   <= '0;
      funct3_q   <= '0;
      off_q      <= '0;
      alu_q      <= '0;
      imm_q      <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      wb_sel_q   <= wb_sel_d;
      funct3_q   <= funct3_d;
      off_q      <= off_d;
      alu_q      <= alu_d;
      imm_q      <= imm_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
    end
  end

  logic [31:0] shifted;
  logic [31:0] load_data;
  logic        bad_access;
  logic [31:0] wdata;

  assign shifted = rdata_q >> {off_q, 3'b000};

  always_comb begin
    load_data = rdata_q;
    case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = rdata_q;
    endcase
  end

  always_comb begin
    bad_access = 1'b0;
    case (funct3_q)
      3'b001, 3'b101:         bad_access = off_q[0];
      3'b010:                 bad_access = (off_q != 2'd0);
      3'b011, 3'b110, 3'b111: bad_access = 1'b1;
      default:                bad_access = 1'b0;
    endcase
  end

  always_comb begin
    wdata = alu_q;
    case (wb_sel_q)
      2'b00:   wdata = alu_q;
      2'b01:   wdata = load_data;
      2'b10:   wdata = pc_q + 32'd4;
      default: wdata = imm_q;
    endcase
  end

  assign load_misaligned = valid_q & (wb_sel_q == 2'b01) & bad_access;
  assign rf_we           = valid_q & regwrite_q & (rd_q != 5'd0) & ~load_misaligned;
  assign rf_rd           = rd_q;
  assign rf_wdata        = wdata;
  assign fwd_valid       = rf_we;
  assign fwd_rd          = rd_q;
  assign fwd_data        = wdata;
  assign commit_valid    = valid_q;
  assign commit_pc       = pc_q;
  assign retired_count   = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage against a transaction-level model.
module tb_wb_stage;

  typedef struct {
    bit        v;
    bit [31:0] pc;
    bit [4:0]  rd;
    bit        rw;
    bit [1:0]  sel;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] alu;
    bit [31:0] imm;
    bit [31:0] rdata;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_stall = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [4:0]  in_rd = '0;
  logic        in_regwrite = 1'b0;
  logic [1:0]  in_wb_sel = '0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_alu_out = '0;
  logic [31:0] in_imm = '0;
  logic [31:0] in_mem_rdata = '0;
  logic        rf_we, fwd_valid, commit_valid, load_misaligned;
  logic [4:0]  rf_rd, fwd_rd;
  logic [31:0] rf_wdata, fwd_data, commit_pc;
  logic [3:0]  retired_count;

  int n_tests = 0;
  int n_fail  = 0;

  rec_t m;
  int   m_cnt = 0;

  wb_stage #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .mem_stall(mem_stall), .in_valid(in_valid),
    .in_pc(in_pc), .in_rd(in_rd), .in_regwrite(in_regwrite), .in_wb_sel(in_wb_sel),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_alu_out(in_alu_out), .in_imm(in_imm),
    .in_mem_rdata(in_mem_rdata), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .load_misaligned(load_misaligned), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  function automatic bit is_bad(rec_t r);
    int off = int'(r.addr % 4);
    if (r.sel != 2'b01) return 1'b0;
    if (r.f3 == 3 || r.f3 == 6 || r.f3 == 7) return 1'b1;
    if ((r.f3 == 1 || r.f3 == 5) && (off % 2 == 1)) return 1'b1;
    if (r.f3 == 2 && off != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit [31:0] exp_data(rec_t r);
    int off = int'(r.addr % 4);
    bit [31:0] b = (r.rdata >> (8 * off)) % 256;
    bit [31:0] h = (r.rdata >> (8 * off)) % 65536;
    case (r.sel)
      2'b00: return r.alu;
      2'b10: return r.pc + 4;
      2'b11: return r.imm;
      default: ;
    endcase
    case (r.f3)
      3'd0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4: return b;
      3'd1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5: return h;
      default: return r.rdata;
    endcase
  endfunction

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clk) begin
    bit ok;
    bit bad, we;
    if (rst) begin
      ok = !rf_we && !fwd_valid && !commit_valid && !load_misaligned && retired_count == 0
           && commit_pc == 0 && rf_rd == 0 && rf_wdata == 0;
    end else begin
      bad = m.v && is_bad(m);
      we  = m.v && m.rw && m.rd != 0 && !bad;
      ok = rf_we == we && fwd_valid == we && commit_valid == m.v
           && load_misaligned == bad && int'(retired_count) == m_cnt;
      if (m.v) ok = ok && commit_pc == m.pc && rf_rd == m.rd && fwd_rd == m.rd;
      if (m.v && !is_bad(m)) ok = ok && rf_wdata == exp_data(m) && fwd_data == exp_data(m);
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL model t=%0t act we=%b cv=%b mis=%b cnt=%0d pc=%h rd=%0d wd=%h exp v=%b pc=%h rd=%0d wd=%h cnt=%0d",
               $time, rf_we, commit_valid, load_misaligned, retired_count, commit_pc, rf_rd,
               rf_wdata, m.v, m.pc, m.rd, exp_data(m), m_cnt);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step(input bit stall, input rec_t r);
    mem_stall    = stall;
    in_valid     = r.v;
    in_pc        = r.pc;
    in_rd        = r.rd;
    in_regwrite  = r.rw;
    in_wb_sel    = r.sel;
    in_funct3    = r.f3;
    in_addr      = r.addr;
    in_alu_out   = r.alu;
    in_imm       = r.imm;
    in_mem_rdata = r.rdata;
    @(posedge clk);
    if (!rst) begin
      if (m.v) m_cnt = (m_cnt + 1) % 16;
      if (stall) m.v = 1'b0;
      else m = r;
    end
    @(negedge clk);
    #1;
  endtask

  function automatic rec_t mk(bit [31:0] pc, bit [4:0] rd, bit [1:0] sel, bit [2:0] f3,
                              bit [31:0] addr, bit [31:0] alu, bit [31:0] imm, bit [31:0] rdata);
    rec_t r;
    r.v = 1'b1; r.pc = pc; r.rd = rd; r.rw = 1'b1; r.sel = sel; r.f3 = f3;
    r.addr = addr; r.alu = alu; r.imm = imm; r.rdata = rdata;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    m = '{default: 0};
    m_cnt = 0;
    #1;
    chk("rst_commit", 32'(commit_valid), 0);
    chk("rst_we", 32'(rf_we), 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_cnt", 32'(retired_count), 0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rel_we", 32'(rf_we), 0);
    chk("rel_commit", 32'(commit_valid), 0);
  endtask

  initial begin
    rec_t r, idle;
    int c0;
    idle = '{default: 0};
    m = '{default: 0};
    do_reset();

    step(0, mk(32'h100, 5, 2'b01, 3'd0, 32'h1002, 0, 0, 32'h80FF_7F01));
    chk("lb_we", 32'(rf_we), 1);
    chk("lb_rd", 32'(rf_rd), 5);
    chk("lb_data", rf_wdata, 32'hFFFF_FFFF);
    step(0, mk(32'h104, 5, 2'b01, 3'd4, 32'h1002, 0, 0, 32'h80FF_7F01));
    chk("lbu_data", rf_wdata, 32'h0000_00FF);
    step(0, mk(32'h108, 6, 2'b01, 3'd1, 32'h2002, 0, 0, 32'h8001_1234));
    chk("lh_data", rf_wdata, 32'hFFFF_8001);
    step(0, mk(32'h10C, 6, 2'b01, 3'd5, 32'h2000, 0, 0, 32'h8001_1234));
    chk("lhu_data", rf_wdata, 32'h0000_1234);
    step(0, mk(32'h110, 6, 2'b01, 3'd1, 32'h2001, 0, 0, 32'h8001_1234));
    chk("lh_mis", 32'(load_misaligned), 1);
    chk("lh_mis_we", 32'(rf_we), 0);
    chk("lh_mis_commit", 32'(commit_valid), 1);
    step(0, mk(32'hFFFF_FFFC, 7, 2'b10, 3'd0, 0, 0, 0, 0));
    chk("pc4_wrap", rf_wdata, 32'h0);
    step(0, mk(32'h114, 7, 2'b11, 3'd0, 0, 0, 32'hABCD_E000, 0));
    chk("imm", rf_wdata, 32'hABCD_E000);
    c0 = int'(retired_count);
    step(0, mk(32'h118, 0, 2'b00, 3'd0, 0, 32'h1234, 0, 0));
    chk("x0_we", 32'(rf_we), 0);
    chk("x0_fwd", 32'(fwd_valid), 0);
    chk("x0_commit", 32'(commit_valid), 1);
    chk("x0_cnt", 32'(retired_count), 32'((c0 + 1) % 16));

    c0 = int'(retired_count);
    r = mk(32'h200, 9, 2'b00, 3'd0, 0, 32'h55, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, r);
      chk("stall_bubble", 32'(commit_valid), 0);
    end
    step(0, r);
    chk("stall_commit", 32'(commit_valid), 1);
    chk("stall_pc", commit_pc, 32'h200);
    step(0, idle);
    chk("stall_once", 32'(commit_valid), 0);
    chk("stall_cnt", 32'(retired_count), 32'((c0 + 2) % 16));

    // Mid-stream asynchronous reset with a valid instruction on the outputs.
    step(0, mk(32'h300, 3, 2'b00, 3'd0, 0, 32'h77, 0, 0));
    chk("pre_rst_we", 32'(rf_we), 1);
    do_reset();
    step(0, idle);
    chk("post_rst_we", 32'(rf_we), 0);

    for (int i = 0; i < 17; i++) step(0, mk(32'h400 + 4 * i, 1, 2'b00, 3'd0, 0, i, 0, 0));
    step(0, idle);
    chk("cnt_wrap17", 32'(retired_count), 1);

    for (int i = 0; i < 400; i++) begin
      r.v     = ($urandom_range(0, 9) < 8);
      r.pc    = $urandom;
      r.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      r.rw    = ($urandom_range(0, 4) != 0);
      r.sel   = 2'($urandom);
      r.f3    = 3'($urandom);
      r.addr  = $urandom;
      r.alu   = $urandom;
      r.imm   = $urandom;
      r.rdata = $urandom;
      if (i % 9 == 0) r.pc = 32'hFFFF_FFFC;
      step($urandom_range(0, 4) == 0, r);
    end
    step(0, idle);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
